// File: rtl/menu_cursor_ctrl.sv
// Menu cursor controller: turns decoded arrow-key presses into debounced single steps over NUM_POS positions.
// Optional hold-to-repeat stepping is built when MENU_CURSOR_AUTO_REPEAT_EN is defined.
module menu_cursor_ctrl #(
  parameter int NUM_POS        = 3,
  parameter int POS_W          = 2,
  parameter int RESET_POS      = 1,
  parameter int WRAP           = 0,
  parameter int LOCKOUT_CYCLES = 2500000,
  parameter int REPEAT_DELAY   = 25000000,
  parameter int REPEAT_PERIOD  = 10000000
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iArriba,
  input  logic             iAbajo,
  input  logic             iInterrupt,
  output logic [POS_W-1:0] oPos,
  output logic             oMove,
  output logic             oDir,
  output logic             oBusy,
  output logic [1:0]       oDbgState
);

  localparam int MAX_AB  = (LOCKOUT_CYCLES > REPEAT_DELAY) ? LOCKOUT_CYCLES : REPEAT_DELAY;
  localparam int MAX_CNT = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [POS_W-1:0] POS_MAX   = POS_W'(NUM_POS - 1);
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
  localparam logic [POS_W-1:0] POS_RST   = POS_W'(RESET_POS);

  typedef enum logic [1:0] {IDLE, STEP, LOCKOUT, HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_dir_lat, w_dir_lat_nxt;   // 1 = up
  logic [CNT_W-1:0] r_lock_cnt, w_lock_cnt_nxt;
  logic [POS_W-1:0] r_pos, w_pos_nxt, w_step_pos;
  logic             r_move, w_move_nxt;
  logic             r_dir, w_dir_nxt;
  logic             w_valid, w_press_up;
`ifdef MENU_CURSOR_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] r_rpt_cnt, w_rpt_cnt_nxt;
  logic             r_rpt_flag, w_rpt_flag_nxt;
`endif

  // Both arrows together, or no key-active flag, is treated as no press.
  assign w_valid    = iInterrupt & (iArriba ^ iAbajo);
  assign w_press_up = w_valid & iArriba;

  // Up moves toward index 0; ends either clamp or wrap.
  always_comb begin
    w_step_pos = r_pos;
    if (r_dir_lat) begin
      if (r_pos == '0) w_step_pos = (WRAP != 0) ? POS_MAX : r_pos;
      else             w_step_pos = r_pos - POS_ONE;
    end else begin
      if (r_pos >= POS_MAX) w_step_pos = (WRAP != 0) ? '0 : POS_MAX;
      else                  w_step_pos = r_pos + POS_ONE;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_dir_lat_nxt  = r_dir_lat;
    w_lock_cnt_nxt = r_lock_cnt;
    w_pos_nxt      = r_pos;
    w_move_nxt     = 1'b0;
    w_dir_nxt      = r_dir;
`ifdef MENU_CURSOR_AUTO_REPEAT_EN
    w_rpt_cnt_nxt  = r_rpt_cnt;
    w_rpt_flag_nxt = r_rpt_flag;
`endif
    case (r_state)
      IDLE: begin
`ifdef MENU_CURSOR_AUTO_REPEAT_EN
        w_rpt_flag_nxt = 1'b0;
`endif
        if (w_valid) begin
          w_dir_lat_nxt = w_press_up;
          w_state_nxt   = STEP;
        end
      end
      STEP: begin
        w_pos_nxt      = w_step_pos;
        w_move_nxt     = (w_step_pos != r_pos);
        w_dir_nxt      = r_dir_lat;
        w_lock_cnt_nxt = LOCK_LOAD;
        w_state_nxt    = LOCKOUT;
      end
      LOCKOUT: begin
        if (r_lock_cnt == '0) begin
          w_state_nxt = HOLD;
`ifdef MENU_CURSOR_AUTO_REPEAT_EN
          w_rpt_cnt_nxt = r_rpt_flag ? PERIOD_LOAD : DELAY_LOAD;
`endif
        end else begin
          w_lock_cnt_nxt = r_lock_cnt - CNT_ONE;
        end
      end
      HOLD: begin
        if (!iInterrupt) begin
          w_state_nxt = IDLE;
        end else if (w_valid && (w_press_up != r_dir_lat)) begin
          w_dir_lat_nxt = w_press_up;
          w_state_nxt   = STEP;
`ifdef MENU_CURSOR_AUTO_REPEAT_EN
          w_rpt_flag_nxt = 1'b0;
`endif
        end
`ifdef MENU_CURSOR_AUTO_REPEAT_EN
        // Counter parks at 0 until the same-direction press is valid again.
        else if (r_rpt_cnt == '0) begin
          if (w_valid) begin
            w_state_nxt    = STEP;
            w_rpt_flag_nxt = 1'b1;
          end
        end else begin
          w_rpt_cnt_nxt = r_rpt_cnt - CNT_ONE;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      r_state    <= IDLE;
      r_dir_lat  <= 1'b0;
      r_lock_cnt <= '0;
      r_pos      <= POS_RST;
      r_move     <= 1'b0;
      r_dir      <= 1'b0;
`ifdef MENU_CURSOR_AUTO_REPEAT_EN
      r_rpt_cnt  <= '0;
      r_rpt_flag <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_dir_lat  <= w_dir_lat_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_pos      <= w_pos_nxt;
      r_move     <= w_move_nxt;
      r_dir      <= w_dir_nxt;
`ifdef MENU_CURSOR_AUTO_REPEAT_EN
      r_rpt_cnt  <= w_rpt_cnt_nxt;
      r_rpt_flag <= w_rpt_flag_nxt;
`endif
    end
  end

  assign oPos      = r_pos;
  assign oMove     = r_move;
  assign oDir      = r_dir;
  assign oBusy     = (r_state != IDLE);
  assign oDbgState = r_state;

endmodule

// File: tb/tb_menu_cursor_ctrl.sv
// Bench for menu_cursor_ctrl: vector table on a saturating instance, hand sequences on a wrapping one.
// The hold-to-repeat sequence is compiled in when MENU_CURSOR_AUTO_REPEAT_EN is defined.
module tb_menu_cursor_ctrl;

  // ---------------- clock / reset / DUTs ----------------
  logic       clk;
  logic       a_rst_n, a_intr, a_up, a_dn;
  logic [1:0] a_pos, a_dbg;
  logic       a_move, a_dir, a_busy;
  logic       w_rst_n, w_intr, w_up, w_dn;
  logic [1:0] w_pos, w_dbg;
  logic       w_move, w_dir, w_busy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  menu_cursor_ctrl #(
    .NUM_POS(3), .POS_W(2), .RESET_POS(1), .WRAP(0),
    .LOCKOUT_CYCLES(4), .REPEAT_DELAY(6), .REPEAT_PERIOD(3)
  ) u_dut_sat (
    .iCLK(clk), .iRST_n(a_rst_n), .iArriba(a_up), .iAbajo(a_dn), .iInterrupt(a_intr),
    .oPos(a_pos), .oMove(a_move), .oDir(a_dir), .oBusy(a_busy), .oDbgState(a_dbg)
  );

  menu_cursor_ctrl #(
    .NUM_POS(3), .POS_W(2), .RESET_POS(1), .WRAP(1),
    .LOCKOUT_CYCLES(4), .REPEAT_DELAY(6), .REPEAT_PERIOD(3)
  ) u_dut_wrap (
    .iCLK(clk), .iRST_n(w_rst_n), .iArriba(w_up), .iAbajo(w_dn), .iInterrupt(w_intr),
    .oPos(w_pos), .oMove(w_move), .oDir(w_dir), .oBusy(w_busy), .oDbgState(w_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string tag;
    logic  rst_n, intr, up, dn;
    int    pos;
    logic  mv, dir, busy;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input string tag, input logic r, input logic i, input logic u,
                              input logic d, input int p, input logic m, input logic dr,
                              input logic b);
    vec_t v;
    v.tag = tag; v.rst_n = r; v.intr = i; v.up = u; v.dn = d;
    v.pos = p; v.mv = m; v.dir = dr; v.busy = b;
    vecs.push_back(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic a_cycle(input logic r, input logic i, input logic u, input logic d);
    @(negedge clk);
    a_rst_n = r; a_intr = i; a_up = u; a_dn = d;
    @(posedge clk);
    #1;
  endtask

  // Every move seen on the wrapping instance must match the next queued position.
  task automatic w_cycle(input logic r, input logic i, input logic u, input logic d);
    logic [1:0] e;
    @(negedge clk);
    w_rst_n = r; w_intr = i; w_up = u; w_dn = d;
    @(posedge clk);
    #1;
    if (w_move) begin
      if (exp_q.size() == 0) chk("w_extra_move", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("w_move_pos", int'(w_pos), int'(e));
      end
    end
  endtask

  task automatic w_release(input int n);
    for (int k = 0; k < n; k++) w_cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- test ----------------
  initial begin
    a_rst_n = 1'b0; a_intr = 1'b0; a_up = 1'b0; a_dn = 1'b0;
    w_rst_n = 1'b0; w_intr = 1'b0; w_up = 1'b0; w_dn = 1'b0;

    // columns: rst_n intr up dn -> pos move dir busy (after the sampling edge)
    add("rst",    0, 0, 0, 0, 1, 0, 0, 0);
    add("idle",   1, 0, 0, 0, 1, 0, 0, 0);
    add("t1_dn",  1, 1, 0, 1, 1, 0, 0, 1);
    add("t1_dn",  1, 1, 0, 1, 2, 1, 0, 1);
    for (int k = 3; k <= 20; k++) add("t1_hold", 1, 1, 0, 1, 2, 0, 0, 1);
    add("t1_rel", 1, 0, 0, 0, 2, 0, 0, 0);
    for (int k = 1; k <= 8; k++) add("t2_sat", 1, 1, 0, 1, 2, 0, 0, 1);
    add("t2_rel", 1, 0, 0, 0, 2, 0, 0, 0);
    add("t3_rst", 0, 0, 0, 0, 1, 0, 0, 0);
    add("t3_up",  1, 1, 1, 0, 1, 0, 0, 1);
    add("t3_up",  1, 1, 1, 0, 0, 1, 1, 1);
    for (int k = 3; k <= 7; k++) add("t3_uphold", 1, 1, 1, 0, 0, 0, 1, 1);
    add("t3_dn",  1, 1, 0, 1, 0, 0, 1, 1);
    add("t3_dn",  1, 1, 0, 1, 1, 1, 0, 1);
    for (int k = 10; k <= 14; k++) add("t3_dnhold", 1, 1, 0, 1, 1, 0, 0, 1);
    add("t3_rel", 1, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 3; k++) add("t4_both", 1, 1, 1, 1, 1, 0, 0, 0);
    add("t4_up",  1, 1, 1, 0, 1, 0, 0, 1);
    add("t4_up",  1, 1, 1, 0, 0, 1, 1, 1);
    add("t4_lk",  1, 0, 0, 0, 0, 0, 1, 1);
    add("t4_pulse", 1, 1, 0, 1, 0, 0, 1, 1);
    add("t4_pulse", 1, 1, 0, 1, 0, 0, 1, 1);
    add("t4_lk",  1, 0, 0, 0, 0, 0, 1, 1);
    add("t4_rel", 1, 0, 0, 0, 0, 0, 1, 0);
    add("t5_top", 1, 1, 1, 0, 0, 0, 1, 1);
    add("t5_top", 1, 1, 1, 0, 0, 0, 1, 1);
    add("t5_top", 1, 1, 1, 0, 0, 0, 1, 1);
    add("t5_rst", 0, 1, 1, 0, 1, 0, 0, 0);
    add("t5_idle", 1, 0, 0, 0, 1, 0, 0, 0);
    add("t5_dn",  1, 1, 0, 1, 1, 0, 0, 1);
    add("t5_dn",  1, 1, 0, 1, 2, 1, 0, 1);
    for (int k = 8; k <= 11; k++) add("t5_lk", 1, 0, 0, 0, 2, 0, 0, 1);
    add("t5_rel", 1, 0, 0, 0, 2, 0, 0, 0);

    for (int n = 0; n < vecs.size(); n++) begin
      a_cycle(vecs[n].rst_n, vecs[n].intr, vecs[n].up, vecs[n].dn);
      chk($sformatf("%s[%0d].pos", vecs[n].tag, n), int'(a_pos), vecs[n].pos);
      chk($sformatf("%s[%0d].move", vecs[n].tag, n), int'(a_move), int'(vecs[n].mv));
      chk($sformatf("%s[%0d].dir", vecs[n].tag, n), int'(a_dir), int'(vecs[n].dir));
      chk($sformatf("%s[%0d].busy", vecs[n].tag, n), int'(a_busy), int'(vecs[n].busy));
    end

    // Wrapping instance: down 1->2, down 2->0, up 0->2.
    w_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("w_rst_pos", int'(w_pos), 1);
    chk("w_rst_busy", int'(w_busy), 0);
    exp_q.push_back(2'd2);
    w_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    chk("w_dn1_busy", int'(w_busy), 1);
    chk("w_dn1_early_move", int'(w_move), 0);
    w_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    chk("w_dn1_move", int'(w_move), 1);
    w_release(5);
    chk("w_dn1_idle", int'(w_busy), 0);
    exp_q.push_back(2'd0);
    w_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    w_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    chk("w_wrap_dn_move", int'(w_move), 1);
    chk("w_wrap_dn_pos", int'(w_pos), 0);
    chk("w_wrap_dn_dir", int'(w_dir), 0);
    w_release(5);
    exp_q.push_back(2'd2);
    w_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    w_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    chk("w_wrap_up_move", int'(w_move), 1);
    chk("w_wrap_up_pos", int'(w_pos), 2);
    chk("w_wrap_up_dir", int'(w_dir), 1);
    w_release(5);
    chk("w_up_idle", int'(w_busy), 0);

`ifdef MENU_CURSOR_AUTO_REPEAT_EN
    // Held down: steps at rows 2, 13 (+1+4+6), then every +1+4+3; release lands on an expiry.
    begin
      int step_rows[5];
      logic want;
      step_rows = '{2, 13, 21, 29, 37};
      w_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t6_rst_pos", int'(w_pos), 1);
      exp_q.push_back(2'd2); exp_q.push_back(2'd0); exp_q.push_back(2'd1);
      exp_q.push_back(2'd2); exp_q.push_back(2'd0);
      for (int row = 1; row <= 43; row++) begin
        w_cycle(1'b1, 1'b1, 1'b0, 1'b1);
        want = 1'b0;
        for (int s = 0; s < 5; s++) if (step_rows[s] == row) want = 1'b1;
        chk($sformatf("t6_move_row%0d", row), int'(w_move), int'(want));
      end
      w_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t6_rel_busy", int'(w_busy), 0);
      chk("t6_rel_move", int'(w_move), 0);
      chk("t6_rel_pos", int'(w_pos), 0);
      w_release(3);
      chk("t6_after_pos", int'(w_pos), 0);
    end
`endif

    chk("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
